pll_dyn_cfg_ctrl: RTL and testbench

- Runtime controller for a PLL with dynamic divider/duty ports. It sequences reset, waits for lock, and reports status.
- Accepts new output-divider/duty settings over a req/ack handshake. Drives the PLL's dyn_* and pll_rst inputs, synchronises and qualifies pll_lock, times out, and auto-relocks on lock loss.
- Sits beside the clock-wizard instance in the system-clock domain; an always-running reference clock, not a PLL output.

---
 rtl/pll_dyn_cfg_pkg.sv | 16 +
 rtl/sync_2ff.sv | 27 ++
 rtl/pll_dyn_cfg_ctrl.sv | 208 ++++++++++++++++++++
 tb/tb_pll_dyn_cfg_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pll_dyn_cfg_pkg.sv
// Shared types and widths for the PLL dynamic-configuration controller.
package pll_dyn_cfg_pkg;

    localparam int DIV_W    = 10;
    localparam int CNT_W    = 16;
    localparam int RELOCK_W = 8;

    typedef enum logic [2:0] {
        RST,
        WAIT_LOCK,
        STABLE,
        LOCKED,
        FAIL
    } state_t;

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser with asynchronous active-low reset.
module sync_2ff #(
    parameter int           W       = 1,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_meta;
    logic [W-1:0] r_sync;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_meta <= RST_VAL;
            r_sync <= RST_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/pll_dyn_cfg_ctrl.sv
// PLL runtime controller: reset sequencing, lock qualification with timeout,
// auto-relock on lock loss, and req/ack loading of dynamic divider/duty values.
module pll_dyn_cfg_ctrl
    import pll_dyn_cfg_pkg::*;
#(
    parameter int               RST_CYCLES    = 16,
    parameter int               LOCK_TIMEOUT  = 65535,
    parameter int               STABLE_CYCLES = 8,
    parameter logic [DIV_W-1:0] ODIV_DEF      = 10'd100,
    parameter logic [DIV_W-1:0] DUTY_DEF      = 10'd100
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cfg_req,
    input  logic [DIV_W-1:0]    cfg_odiv0,
    input  logic [DIV_W-1:0]    cfg_odiv1,
    input  logic [DIV_W-1:0]    cfg_duty0,
    input  logic [DIV_W-1:0]    cfg_duty1,
    output logic                cfg_ack,
    output logic                cfg_err,
    input  logic                pll_lock,
    output logic                pll_rst,
    output logic [DIV_W-1:0]    dyn_odiv0,
    output logic [DIV_W-1:0]    dyn_odiv1,
    output logic [DIV_W-1:0]    dyn_duty0,
    output logic [DIV_W-1:0]    dyn_duty1,
    output logic                locked,
    output logic                busy,
    output logic                done,
    output logic                err_timeout,
    output logic                lock_lost,
    output logic [RELOCK_W-1:0] relock_cnt,
    output logic [2:0]          dbg_state
);

    localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TMO_LAST    = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);

    state_t                r_state;
    state_t                w_next;
    logic [CNT_W-1:0]      r_cnt;
    logic [CNT_W-1:0]      r_tmo;
    logic                  w_lock_s;
    logic                  w_cfg_valid;
    logic                  w_cfg_take;
    logic                  w_cfg_accept;
    logic                  w_cfg_reject;
    logic                  w_timeout;
    logic                  w_enter_locked;
    logic                  w_lost;

    logic                  r_pll_rst;
    logic                  r_locked;
    logic                  r_busy;
    logic                  r_cfg_ack;
    logic                  r_cfg_err;
    logic                  r_done;
    logic                  r_err_timeout;
    logic                  r_lock_lost;
    logic [RELOCK_W-1:0]   r_relock_cnt;
    logic [DIV_W-1:0]      r_odiv0;
    logic [DIV_W-1:0]      r_odiv1;
    logic [DIV_W-1:0]      r_duty0;
    logic [DIV_W-1:0]      r_duty1;

    sync_2ff #(.W(1), .RST_VAL(1'b0)) u_lock_sync (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_d     (pll_lock),
        .o_q     (w_lock_s)
    );

    // Handshake: cfg_req is a level sampled only in LOCKED or FAIL; a single
    // cfg_ack pulse (with cfg_err when rejected) consumes it. The cycle that
    // shows cfg_ack is never re-evaluated, so a requester dropping req then
    // is not acked twice.
    assign w_cfg_valid = (cfg_odiv0 != '0) && (cfg_odiv1 != '0);
    assign w_cfg_take  = cfg_req && !r_cfg_ack;

    always_comb begin
        w_next         = r_state;
        w_cfg_accept   = 1'b0;
        w_cfg_reject   = 1'b0;
        w_timeout      = 1'b0;
        w_enter_locked = 1'b0;
        w_lost         = 1'b0;
        case (r_state)
            RST: begin
                if (r_cnt == RST_LAST) w_next = WAIT_LOCK;
            end
            WAIT_LOCK: begin
                if (w_lock_s) begin
                    w_next = STABLE;
                end else if (r_tmo >= TMO_LAST) begin
                    w_next    = FAIL;
                    w_timeout = 1'b1;
                end
            end
            STABLE: begin
                // Timeout is checked before a bounce so it can't be skipped.
                if (w_lock_s && r_cnt == STABLE_LAST) begin
                    w_next         = LOCKED;
                    w_enter_locked = 1'b1;
                end else if (r_tmo >= TMO_LAST) begin
                    w_next    = FAIL;
                    w_timeout = 1'b1;
                end else if (!w_lock_s) begin
                    w_next = WAIT_LOCK;
                end
            end
            LOCKED: begin
                if (!w_lock_s) begin
                    w_next = RST;
                    w_lost = 1'b1;
                end else if (w_cfg_take) begin
                    if (w_cfg_valid) begin
                        w_next       = RST;
                        w_cfg_accept = 1'b1;
                    end else begin
                        w_cfg_reject = 1'b1;
                    end
                end
            end
            FAIL: begin
                if (w_cfg_take) begin
                    if (w_cfg_valid) begin
                        w_next       = RST;
                        w_cfg_accept = 1'b1;
                    end else begin
                        w_cfg_reject = 1'b1;
                    end
                end
            end
            default: w_next = RST;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= RST;
            r_cnt   <= '0;
            r_tmo   <= '0;
        end else begin
            r_state <= w_next;
            r_cnt   <= (w_next != r_state) ? '0 : r_cnt + 1'b1;
            // tmo spans WAIT_LOCK and STABLE together, so bounces don't restart it.
            if (r_state == RST) begin
                r_tmo <= '0;
            end else if ((r_state == WAIT_LOCK || r_state == STABLE) && r_tmo != '1) begin
                r_tmo <= r_tmo + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pll_rst     <= 1'b1;
            r_locked      <= 1'b0;
            r_busy        <= 1'b1;
            r_cfg_ack     <= 1'b0;
            r_cfg_err     <= 1'b0;
            r_done        <= 1'b0;
            r_err_timeout <= 1'b0;
            r_lock_lost   <= 1'b0;
            r_relock_cnt  <= '0;
            r_odiv0       <= ODIV_DEF;
            r_odiv1       <= ODIV_DEF;
            r_duty0       <= DUTY_DEF;
            r_duty1       <= DUTY_DEF;
        end else begin
            r_pll_rst     <= (w_next == RST);
            r_locked      <= (w_next == LOCKED);
            r_busy        <= (w_next != LOCKED) && (w_next != FAIL);
            r_cfg_ack     <= w_cfg_accept || w_cfg_reject;
            r_cfg_err     <= w_cfg_reject;
            r_done        <= w_enter_locked;
            r_err_timeout <= w_timeout;
            r_lock_lost   <= w_lost;
            if (w_lost && r_relock_cnt != '1) begin
                r_relock_cnt <= r_relock_cnt + 1'b1;
            end
            // Loading only on accept keeps dyn_* still while pll_rst is low.
            if (w_cfg_accept) begin
                r_odiv0 <= cfg_odiv0;
                r_odiv1 <= cfg_odiv1;
                r_duty0 <= cfg_duty0;
                r_duty1 <= cfg_duty1;
            end
        end
    end

    assign pll_rst     = r_pll_rst;
    assign locked      = r_locked;
    assign busy        = r_busy;
    assign cfg_ack     = r_cfg_ack;
    assign cfg_err     = r_cfg_err;
    assign done        = r_done;
    assign err_timeout = r_err_timeout;
    assign lock_lost   = r_lock_lost;
    assign relock_cnt  = r_relock_cnt;
    assign dyn_odiv0   = r_odiv0;
    assign dyn_odiv1   = r_odiv1;
    assign dyn_duty0   = r_duty0;
    assign dyn_duty1   = r_duty1;
    assign dbg_state   = r_state;

endmodule

// File: tb/tb_pll_dyn_cfg_ctrl.sv
// Self-checking bench for pll_dyn_cfg_ctrl with a behavioural PLL lock model
// and event timing predicted from the controller's cycle rules.
module tb_pll_dyn_cfg_ctrl;

    localparam int         RST_CYCLES    = 16;
    localparam int         LOCK_TIMEOUT  = 100;
    localparam int         STABLE_CYCLES = 8;
    localparam logic [9:0] ODIV_DEF      = 10'd100;
    localparam logic [9:0] DUTY_DEF      = 10'd100;

    // clock / reset / DUT
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cfg_req = 1'b0;
    logic [9:0] cfg_odiv0 = '0, cfg_odiv1 = '0, cfg_duty0 = '0, cfg_duty1 = '0;
    logic       pll_lock = 1'b0;
    logic       cfg_ack, cfg_err, pll_rst, locked, busy, done, err_timeout, lock_lost;
    logic [9:0] dyn_odiv0, dyn_odiv1, dyn_duty0, dyn_duty1;
    logic [7:0] relock_cnt;
    logic [2:0] dbg_state;

    always #5 clk = ~clk;

    pll_dyn_cfg_ctrl #(
        .RST_CYCLES   (RST_CYCLES),
        .LOCK_TIMEOUT (LOCK_TIMEOUT),
        .STABLE_CYCLES(STABLE_CYCLES),
        .ODIV_DEF     (ODIV_DEF),
        .DUTY_DEF     (DUTY_DEF)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cfg_req    (cfg_req),
        .cfg_odiv0  (cfg_odiv0),
        .cfg_odiv1  (cfg_odiv1),
        .cfg_duty0  (cfg_duty0),
        .cfg_duty1  (cfg_duty1),
        .cfg_ack    (cfg_ack),
        .cfg_err    (cfg_err),
        .pll_lock   (pll_lock),
        .pll_rst    (pll_rst),
        .dyn_odiv0  (dyn_odiv0),
        .dyn_odiv1  (dyn_odiv1),
        .dyn_duty0  (dyn_duty0),
        .dyn_duty1  (dyn_duty1),
        .locked     (locked),
        .busy       (busy),
        .done       (done),
        .err_timeout(err_timeout),
        .lock_lost  (lock_lost),
        .relock_cnt (relock_cnt),
        .dbg_state  (dbg_state)
    );

    // scoreboard state
    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    int          lock_delay = 40;
    bit          lock_en = 1'b1;
    int          low_cnt = 0;
    int          lock_rise_cyc = -1;
    int          done_seen = 0, tmo_seen = 0, lost_seen = 0;
    int          exp_relock = 0;
    logic [39:0] exp_q[$];
    logic [39:0] cur_dyn = {ODIV_DEF, ODIV_DEF, DUTY_DEF, DUTY_DEF};

    initial begin
        #5_000_000;
        $display("FAIL watchdog: sim time limit reached at cyc %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h exp=%0h (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    // One clock: sample point is #1 after the edge; PLL model reacts to pll_rst.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (done)        done_seen++;
        if (err_timeout) tmo_seen++;
        if (lock_lost)   lost_seen++;
        if (pll_rst) begin
            low_cnt  = 0;
            pll_lock = 1'b0;
        end else begin
            if (lock_en && low_cnt == lock_delay) begin
                pll_lock      = 1'b1;
                lock_rise_cyc = cyc;
            end
            low_cnt++;
        end
    endtask

    function automatic bit ev_hit(input int which);
        case (which)
            0:       return done;
            1:       return !pll_rst;
            2:       return err_timeout;
            default: return 1'b0;
        endcase
    endfunction

    task automatic wait_ev(input int which, input int budget, output int at);
        at = -1;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (ev_hit(which)) begin
                at = cyc;
                return;
            end
        end
    endtask

    task automatic check_reset(input string tag);
        check_eq({tag, "_pll_rst"}, pll_rst, 1);
        check_eq({tag, "_busy"}, busy, 1);
        check_eq({tag, "_locked"}, locked, 0);
        check_eq({tag, "_dyn"}, {dyn_odiv0, dyn_odiv1, dyn_duty0, dyn_duty1},
                 {ODIV_DEF, ODIV_DEF, DUTY_DEF, DUTY_DEF});
        check_eq({tag, "_relock_cnt"}, relock_cnt, 0);
        check_eq({tag, "_pulses"}, {cfg_ack, cfg_err, done, err_timeout, lock_lost}, 0);
    endtask

    // pll_rst went high at rst_start; expect 16-cycle reset, then done
    // 1 capture edge + 2 sync edges + STABLE_CYCLES after the lock rise.
    task automatic expect_lock_seq(input int rst_start);
        int at;
        wait_ev(1, 200, at);
        check_eq("pll_rst_len", at - rst_start, RST_CYCLES);
        wait_ev(0, LOCK_TIMEOUT + 20, at);
        check_eq("done_cycle", at, lock_rise_cyc + 3 + STABLE_CYCLES);
        check_eq("locked", locked, 1);
        check_eq("busy_locked", busy, 0);
        check_eq("dyn_hold", {dyn_odiv0, dyn_odiv1, dyn_duty0, dyn_duty1}, cur_dyn);
        tick();
        check_eq("done_width", done, 0);
    endtask

    // Driver: present a request in LOCKED/FAIL and check the ack cycle.
    task automatic do_cfg(input logic [9:0] o0, input logic [9:0] o1,
                          input logic [9:0] d0, input logic [9:0] d1, output int ack_at);
        bit valid;
        valid = (o0 != 0) && (o1 != 0);
        if (valid) exp_q.push_back({o0, o1, d0, d1});
        cfg_odiv0 = o0; cfg_odiv1 = o1; cfg_duty0 = d0; cfg_duty1 = d1;
        cfg_req = 1'b1;
        tick();
        ack_at = cyc;
        check_eq("cfg_ack", cfg_ack, 1);
        check_eq("cfg_err", cfg_err, !valid);
        if (valid) cur_dyn = exp_q.pop_front();
        check_eq("dyn_on_ack", {dyn_odiv0, dyn_odiv1, dyn_duty0, dyn_duty1}, cur_dyn);
        check_eq("pll_rst_on_ack", pll_rst, valid);
        cfg_req = 1'b0;
    endtask

    initial begin
        int at, f, c, h, l, rst_start, base_done, base_tmo, base_lost;
        bit bad;
        logic [9:0] o0, o1, d0, d1;

        // power-up
        repeat (5) tick();
        check_reset("por");
        rst_n = 1'b1;
        rst_start = cyc;
        expect_lock_seq(rst_start);
        check_eq("relock_cnt_por", relock_cnt, 0);

        // directed reconfig
        lock_delay = $urandom_range(2, 20);
        do_cfg(10'd200, 10'd50, 10'd200, 10'd50, at);
        tick();
        check_eq("ack_width", cfg_ack, 0);
        expect_lock_seq(at);
        check_eq("relock_cnt_cfg", relock_cnt, 0);

        // randomized reconfigs, some rejected for a zero divider
        for (int i = 0; i < 6; i++) begin
            lock_delay = $urandom_range(2, 20);
            bad = ($urandom_range(0, 2) == 0);
            o0 = 10'($urandom_range(1, 1023)); o1 = 10'($urandom_range(1, 1023));
            d0 = 10'($urandom_range(0, 1023)); d1 = 10'($urandom_range(0, 1023));
            if (bad) begin
                if ($urandom_range(0, 1) == 1) o0 = '0; else o1 = '0;
            end
            do_cfg(o0, o1, d0, d1, at);
            tick();
            if (bad) begin
                check_eq("rej_locked", locked, 1);
                check_eq("rej_pll_rst", pll_rst, 0);
            end else begin
                expect_lock_seq(at);
            end
        end

        // lock glitch: high h, low l, then high for good
        lock_en = 1'b0;
        do_cfg(10'($urandom_range(1, 1023)), 10'($urandom_range(1, 1023)),
               10'($urandom_range(0, 1023)), 10'($urandom_range(0, 1023)), at);
        wait_ev(1, 200, f);
        check_eq("glitch_rst_len", f - at, RST_CYCLES);
        base_done = done_seen;
        base_tmo  = tmo_seen;
        repeat ($urandom_range(2, 15)) tick();
        h = $urandom_range(1, STABLE_CYCLES);
        l = $urandom_range(1, 5);
        pll_lock = 1'b1;
        repeat (h) tick();
        pll_lock = 1'b0;
        repeat (l) tick();
        pll_lock = 1'b1;
        lock_rise_cyc = cyc;
        check_eq("glitch_no_early_done", done_seen - base_done, 0);
        wait_ev(0, LOCK_TIMEOUT, at);
        check_eq("glitch_done_cycle", at, lock_rise_cyc + 3 + STABLE_CYCLES);
        check_eq("glitch_no_timeout", tmo_seen - base_tmo, 0);

        // timeout: lock never comes back
        do_cfg(10'd7, 10'd9, 10'd3, 10'd4, at);
        wait_ev(1, 200, f);
        check_eq("tmo_rst_len", f - at, RST_CYCLES);
        cfg_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("busy_req_ignored", cfg_ack, 0);
        end
        cfg_req = 1'b0;
        wait_ev(2, 200, at);
        check_eq("tmo_cycle", at - f, LOCK_TIMEOUT);
        check_eq("fail_busy", busy, 0);
        check_eq("fail_locked", locked, 0);
        check_eq("fail_pll_rst", pll_rst, 0);
        tick();
        check_eq("tmo_width", err_timeout, 0);
        do_cfg(10'd0, 10'd5, 10'd5, 10'd5, at);
        tick();
        check_eq("fail_rej_busy", busy, 0);
        check_eq("fail_rej_pll_rst", pll_rst, 0);
        lock_en = 1'b1;
        lock_delay = $urandom_range(2, 20);
        do_cfg(10'($urandom_range(1, 1023)), 10'($urandom_range(1, 1023)),
               10'($urandom_range(0, 1023)), 10'($urandom_range(0, 1023)), at);
        expect_lock_seq(at);

        // lock loss with a same-cycle request, until relock_cnt saturates
        base_lost = lost_seen;
        for (int i = 0; i < 260; i++) begin
            pll_lock = 1'b0;
            c = cyc;
            tick();
            tick();
            cfg_odiv0 = 10'($urandom_range(1, 1023)); cfg_odiv1 = 10'($urandom_range(1, 1023));
            cfg_req = 1'b1;
            tick();
            exp_relock = (exp_relock < 255) ? exp_relock + 1 : 255;
            check_eq("lock_lost_cycle", {lock_lost, 32'(cyc - c)}, {1'b1, 32'd3});
            check_eq("lost_no_ack", cfg_ack, 0);
            check_eq("relock_cnt", relock_cnt, exp_relock);
            lock_delay = $urandom_range(2, 8);
            cfg_req = 1'b0;
            rst_start = cyc;
            tick();
            check_eq("lost_width", {lock_lost, cfg_ack}, 0);
            expect_lock_seq(rst_start);
        end
        check_eq("lost_total", lost_seen - base_lost, 260);

        // zero divider in LOCKED
        do_cfg(10'd33, 10'd0, 10'd44, 10'd55, at);
        tick();
        check_eq("inv_locked", locked, 1);
        check_eq("inv_pll_rst", pll_rst, 0);
        check_eq("inv_dyn", {dyn_odiv0, dyn_odiv1, dyn_duty0, dyn_duty1}, cur_dyn);

        // asynchronous reset in the middle of WAIT_LOCK
        lock_en = 1'b0;
        do_cfg(10'd11, 10'd22, 10'd33, 10'd44, at);
        wait_ev(1, 200, f);
        repeat (10) tick();
        #2;
        rst_n = 1'b0;
        #1;
        check_reset("midrst");
        repeat (3) tick();
        rst_n = 1'b1;
        cur_dyn    = {ODIV_DEF, ODIV_DEF, DUTY_DEF, DUTY_DEF};
        exp_relock = 0;
        lock_en    = 1'b1;
        lock_delay = 10;
        rst_start  = cyc;
        expect_lock_seq(rst_start);
        check_eq("relock_cnt_after_rst", relock_cnt, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
